// File: rtl/dmem_mmio_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dmem_mmio_pkg
// Description : Shared constants, register layout and helpers for dmem_mmio.
// Revision    : 1.0 - initial release
// ============================================================================
package dmem_mmio_pkg;

  // Byte offsets of the peripheral registers from the window base
  localparam logic [31:0] OFS_SW     = 32'h0000_0000;
  localparam logic [31:0] OFS_LED    = 32'h0000_0004;
  localparam logic [31:0] OFS_TCOUNT = 32'h0000_0008;
  localparam logic [31:0] OFS_TCMP   = 32'h0000_000C;
  localparam logic [31:0] OFS_TCTRL  = 32'h0000_0010;

  // Bit positions inside TCTRL
  localparam int TCTRL_EN   = 0;
  localparam int TCTRL_AR   = 1;
  localparam int TCTRL_IE   = 2;
  localparam int TCTRL_FLAG = 3;

  // Field order matches the bit positions above (flag is bit 3, en is bit 0)
  typedef struct packed {
    logic flag;
    logic ie;
    logic autoreload;
    logic en;
  } tctrl_t;

  // Replace the bytes of old_v selected by be with the bytes of new_v
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  be);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) begin
      r[8*i +: 8] = be[i] ? new_v[8*i +: 8] : old_v[8*i +: 8];
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_mmio_if.sv
`default_nettype none
// ============================================================================
// Module      : dmem_mmio_if
// Description : Core data-port bus (address, write data/enables, read data).
// Revision    : 1.0 - initial release
// ============================================================================
interface dmem_mmio_if;
  logic        we;
  logic [3:0]  be;
  logic [31:0] a;
  logic [31:0] wd;
  logic [31:0] rd;

  modport master (output we, output be, output a, output wd, input rd);
  modport slave  (input we, input be, input a, input wd, output rd);
endinterface
`default_nettype wire

// File: rtl/dmem_mmio_sw_debounce.sv
`default_nettype none
// ============================================================================
// Module      : sw_debounce
// Description : Two-flop synchroniser followed by a stable-count debouncer.
// Revision    : 1.0 - initial release
// ============================================================================
module sw_debounce #(
  parameter int W      = 10,
  parameter int CYCLES = 16
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [W-1:0] raw,
  output logic [W-1:0] stable
);

  localparam int            CW        = (CYCLES > 1) ? $clog2(CYCLES) : 1;
  localparam logic [CW-1:0] DCNT_LAST = CW'(CYCLES - 1);

  logic [W-1:0]  sync1_q, sync2_q, cand_q, stable_q;
  logic [CW-1:0] dcnt_q;

  // Synchronise the raw pins, then accept a value only after it has been
  // unchanged for CYCLES consecutive cycles; any change restarts the count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      cand_q   <= '0;
      dcnt_q   <= '0;
      stable_q <= '0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      if (sync2_q != cand_q) begin
        cand_q <= sync2_q;
        dcnt_q <= '0;
      end else if (dcnt_q == DCNT_LAST) begin
        stable_q <= cand_q;
      end else begin
        dcnt_q <= dcnt_q + CW'(1);
      end
    end
  end

  assign stable = stable_q;

endmodule
`default_nettype wire

// File: rtl/dmem_mmio.sv
`default_nettype none
// ============================================================================
// Module      : dmem_mmio
// Description : Data RAM with byte-lane writes plus a peripheral window
//               (debounced switches, LED register, compare timer with irq).
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_mmio
  import dmem_mmio_pkg::*;
#(
  parameter int          RAM_WORDS       = 64,
  parameter int          SW_W            = 10,
  parameter int          LED_W           = 10,
  parameter int          DEBOUNCE_CYCLES = 16,
  parameter logic [31:0] MMIO_BASE       = 32'hC000_0000
) (
  input  logic             clk,
  input  logic             reset_n,
  dmem_mmio_if.slave       bus,
  input  logic [SW_W-1:0]  switches,
  output logic [LED_W-1:0] leds,
  output logic             irq
);

  localparam int AW = $clog2(RAM_WORDS);

  logic [31:0] ram_q [RAM_WORDS];

  logic [LED_W-1:0] led_q, led_d;
  logic [31:0]      tcount_q, tcount_d;
  logic [31:0]      tcmp_q, tcmp_d;
  tctrl_t           tctrl_q, tctrl_d;
  logic [SW_W-1:0]  w_sw_stable;

  logic [31:0]   w_word_addr;
  logic [AW-1:0] w_ram_idx;
  logic          w_sel_ram, w_sel_sw, w_sel_led, w_sel_tcount, w_sel_tcmp, w_sel_tctrl;
  logic          w_match;
  logic [31:0]   w_rd;
  logic          w_unused_addr;

  sw_debounce #(
    .W      (SW_W),
    .CYCLES (DEBOUNCE_CYCLES)
  ) u_sw_debounce (
    .clk     (clk),
    .reset_n (reset_n),
    .raw     (switches),
    .stable  (w_sw_stable)
  );

  // Address decode ignores the byte offset within a word
  assign w_word_addr   = {bus.a[31:2], 2'b00};
  assign w_ram_idx     = bus.a[AW+1:2];
  assign w_sel_ram     = (bus.a[31:AW+2] == '0);
  assign w_sel_sw      = (w_word_addr == MMIO_BASE + OFS_SW);
  assign w_sel_led     = (w_word_addr == MMIO_BASE + OFS_LED);
  assign w_sel_tcount  = (w_word_addr == MMIO_BASE + OFS_TCOUNT);
  assign w_sel_tcmp    = (w_word_addr == MMIO_BASE + OFS_TCMP);
  assign w_sel_tctrl   = (w_word_addr == MMIO_BASE + OFS_TCTRL);
  assign w_unused_addr = &{1'b0, bus.a[1:0]};

  assign w_match = tctrl_q.en && (tcount_q == tcmp_q);

  // RAM byte-lane writes; contents deliberately survive reset
  always_ff @(posedge clk) begin
    if (bus.we && w_sel_ram) begin
      for (int i = 0; i < 4; i++) begin
        if (bus.be[i]) ram_q[w_ram_idx][8*i +: 8] <= bus.wd[8*i +: 8];
      end
    end
  end

  // Next state for LED and timer registers; CPU writes override the timer,
  // and a compare match overrides a write-1-to-clear of FLAG.
  always_comb begin
    led_d    = led_q;
    tcount_d = tcount_q;
    tcmp_d   = tcmp_q;
    tctrl_d  = tctrl_q;
    if (tctrl_q.en) begin
      tcount_d = (w_match && tctrl_q.autoreload) ? 32'd0 : tcount_q + 32'd1;
    end
    if (bus.we && w_sel_tcount) tcount_d = merge_bytes(tcount_q, bus.wd, bus.be);
    if (bus.we && w_sel_tcmp)   tcmp_d   = merge_bytes(tcmp_q, bus.wd, bus.be);
    if (bus.we && w_sel_led)    led_d    = LED_W'(merge_bytes(32'(led_q), bus.wd, bus.be));
    if (bus.we && w_sel_tctrl && bus.be[0]) begin
      tctrl_d.en         = bus.wd[TCTRL_EN];
      tctrl_d.autoreload = bus.wd[TCTRL_AR];
      tctrl_d.ie         = bus.wd[TCTRL_IE];
      if (bus.wd[TCTRL_FLAG]) tctrl_d.flag = 1'b0;
    end
    if (w_match) tctrl_d.flag = 1'b1;
  end

  // Peripheral register state with asynchronous reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      led_q    <= '0;
      tcount_q <= '0;
      tcmp_q   <= 32'hFFFF_FFFF;
      tctrl_q  <= '0;
    end else begin
      led_q    <= led_d;
      tcount_q <= tcount_d;
      tcmp_q   <= tcmp_d;
      tctrl_q  <= tctrl_d;
    end
  end

  // Zero-latency read mux; unmapped addresses read as zero
  always_comb begin
    w_rd = '0;
    if (w_sel_ram)         w_rd = ram_q[w_ram_idx];
    else if (w_sel_sw)     w_rd = 32'(w_sw_stable);
    else if (w_sel_led)    w_rd = 32'(led_q);
    else if (w_sel_tcount) w_rd = tcount_q;
    else if (w_sel_tcmp)   w_rd = tcmp_q;
    else if (w_sel_tctrl)  w_rd = 32'(tctrl_q);
  end

  assign bus.rd = w_rd;
  assign leds   = led_q;
  assign irq    = tctrl_q.flag & tctrl_q.ie;

endmodule
`default_nettype wire
